// File: rtl/attack_scheduler.sv
// attack_scheduler
// Runs one round of gameplay: a fixed series of attacks, each preceded by a
// pause gap, while tracking player HP from collision events. The round ends
// with a one-cycle game_over, victory or menu_on pulse to the background FSM.
// Time is counted in frames; a frame tick is a rising edge of vblnk_in.

module attack_scheduler #(
   parameter int NUM_ATTACKS           = 4,
   parameter int GAP_FRAMES            = 60,
   parameter int ATTACK_TIMEOUT_FRAMES = 600,
   parameter int START_HP              = 5,
   parameter int HIT_COOLDOWN_FRAMES   = 30
) (
   input  logic       pclk,
   input  logic       rst,
   input  logic       play_selected,
   input  logic       vblnk_in,
   input  logic       attack_done,
   input  logic       collision,
   input  logic       btn_menu,
   output logic       attack_start,
   output logic [2:0] attack_id,
   output logic       attack_active,
   output logic [3:0] hp,
   output logic       game_over,
   output logic       victory,
   output logic       menu_on
);

   localparam logic [9:0] GAP_LAST      = 10'(GAP_FRAMES - 1);
   localparam logic [9:0] TIMEOUT_LAST  = 10'(ATTACK_TIMEOUT_FRAMES - 1);
   localparam logic [9:0] COOLDOWN_LOAD = 10'(HIT_COOLDOWN_FRAMES);
   localparam logic [3:0] HP_LOAD       = 4'(START_HP);
   localparam logic [2:0] LAST_ID       = 3'(NUM_ATTACKS - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      GAP       = 3'd1,
      START     = 3'd2,
      RUN       = 3'd3,
      WAIT_EXIT = 3'd4
   } state_t;

   state_t     state_r;
   state_t     state_s;
   logic [9:0] frame_cnt_r;
   logic [9:0] frame_cnt_s;
   logic [9:0] cooldown_r;
   logic [9:0] cooldown_s;
   logic       vblnk_q_r;

   logic       tick_s;
   logic       hit_s;
   logic       fatal_s;
   logic       attack_end_s;
   logic [3:0] hp_hit_s;
   logic [9:0] cooldown_hit_s;

   logic [3:0] hp_s;
   logic [2:0] attack_id_s;
   logic       attack_start_s;
   logic       attack_active_s;
   logic       game_over_s;
   logic       victory_s;
   logic       menu_on_s;

   // Frame tick: first cycle in which vblnk_in is seen high.
   assign tick_s = vblnk_in & ~vblnk_q_r;

   // A hit only lands in GAP/RUN when the invulnerability window has expired;
   // the hp != 0 term keeps hp from ever wrapping.
   assign hit_s = collision && (cooldown_r == 10'd0) && (hp != 4'd0) &&
                  ((state_r == GAP) || (state_r == RUN));
   assign fatal_s = hit_s && (hp == 4'd1);

   // An attack ends on its done strobe or when its frame budget runs out.
   assign attack_end_s = (state_r == RUN) &&
                         (attack_done || (tick_s && (frame_cnt_r == TIMEOUT_LAST)));

   // Delay vblnk_in by one cycle for edge detection.
   always_ff @(posedge pclk) begin
      if (rst) begin
         vblnk_q_r <= 1'b0;
      end else begin
         vblnk_q_r <= vblnk_in;
      end
   end

   // HP / cooldown update assuming the round is in a hit-sensitive state;
   // the FSM decides whether to apply it.
   always_comb begin
      hp_hit_s       = hp;
      cooldown_hit_s = cooldown_r;
      if (hit_s) begin
         hp_hit_s       = hp - 4'd1;
         cooldown_hit_s = COOLDOWN_LOAD;
      end else if (tick_s && (cooldown_r != 10'd0)) begin
         cooldown_hit_s = cooldown_r - 10'd1;
      end else begin
         cooldown_hit_s = cooldown_r;
      end
   end

   // FSM state register.
   always_ff @(posedge pclk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state, counters, HP and output pulses; priority inside a round is
   // play drop > menu > fatal hit > attack end.
   always_comb begin
      state_s     = state_r;
      frame_cnt_s = frame_cnt_r;
      cooldown_s  = cooldown_r;
      hp_s        = hp;
      attack_id_s = attack_id;
      game_over_s = 1'b0;
      victory_s   = 1'b0;
      menu_on_s   = 1'b0;

      case (state_r)
         IDLE: begin
            frame_cnt_s = 10'd0;
            cooldown_s  = 10'd0;
            if (play_selected) begin
               state_s = GAP;
            end else begin
               state_s = IDLE;
            end
         end

         GAP: begin
            if (!play_selected) begin
               state_s = IDLE;
            end else if (btn_menu) begin
               menu_on_s = 1'b1;
               state_s   = WAIT_EXIT;
            end else begin
               hp_s       = hp_hit_s;
               cooldown_s = cooldown_hit_s;
               if (fatal_s) begin
                  game_over_s = 1'b1;
                  state_s     = WAIT_EXIT;
               end else if (tick_s) begin
                  if (frame_cnt_r == GAP_LAST) begin
                     frame_cnt_s = 10'd0;
                     state_s     = START;
                  end else begin
                     frame_cnt_s = frame_cnt_r + 10'd1;
                  end
               end else begin
                  frame_cnt_s = frame_cnt_r;
               end
            end
         end

         START: begin
            if (!play_selected) begin
               state_s = IDLE;
            end else if (btn_menu) begin
               menu_on_s = 1'b1;
               state_s   = WAIT_EXIT;
            end else begin
               frame_cnt_s = 10'd0;
               state_s     = RUN;
            end
         end

         RUN: begin
            if (!play_selected) begin
               state_s = IDLE;
            end else if (btn_menu) begin
               menu_on_s = 1'b1;
               state_s   = WAIT_EXIT;
            end else begin
               hp_s       = hp_hit_s;
               cooldown_s = cooldown_hit_s;
               if (fatal_s) begin
                  game_over_s = 1'b1;
                  state_s     = WAIT_EXIT;
               end else if (attack_end_s) begin
                  if (attack_id == LAST_ID) begin
                     victory_s = 1'b1;
                     state_s   = WAIT_EXIT;
                  end else begin
                     attack_id_s = attack_id + 3'd1;
                     frame_cnt_s = 10'd0;
                     state_s     = GAP;
                  end
               end else if (tick_s) begin
                  frame_cnt_s = frame_cnt_r + 10'd1;
               end else begin
                  frame_cnt_s = frame_cnt_r;
               end
            end
         end

         WAIT_EXIT: begin
            if (!play_selected) begin
               state_s = IDLE;
            end else begin
               state_s = WAIT_EXIT;
            end
         end

         default: begin
            state_s = IDLE;
         end
      endcase

      // IDLE shows a fresh HP; attack_id reads 0 whenever no round is live.
      if (state_s == IDLE) begin
         hp_s        = HP_LOAD;
         attack_id_s = 3'd0;
      end else if (state_s == WAIT_EXIT) begin
         attack_id_s = 3'd0;
      end else begin
         attack_id_s = attack_id_s;
      end

      attack_start_s  = (state_s == START);
      attack_active_s = (state_s == START) || (state_s == RUN);
   end

   // Frame/cooldown counters and all registered outputs.
   always_ff @(posedge pclk) begin
      if (rst) begin
         frame_cnt_r   <= 10'd0;
         cooldown_r    <= 10'd0;
         hp            <= HP_LOAD;
         attack_id     <= 3'd0;
         attack_start  <= 1'b0;
         attack_active <= 1'b0;
         game_over     <= 1'b0;
         victory       <= 1'b0;
         menu_on       <= 1'b0;
      end else begin
         frame_cnt_r   <= frame_cnt_s;
         cooldown_r    <= cooldown_s;
         hp            <= hp_s;
         attack_id     <= attack_id_s;
         attack_start  <= attack_start_s;
         attack_active <= attack_active_s;
         game_over     <= game_over_s;
         victory       <= victory_s;
         menu_on       <= menu_on_s;
      end
   end

endmodule

// File: tb/tb_attack_scheduler.sv
// Directed bench for attack_scheduler. Main instance: NUM_ATTACKS=2,
// GAP_FRAMES=2, ATTACK_TIMEOUT_FRAMES=4, START_HP=5, HIT_COOLDOWN_FRAMES=3.
// Second instance is identical except START_HP=1, for the fatal-hit case.

module tb_attack_scheduler;

   logic       pclk;
   logic       rst;
   logic       vblnk;
   logic       play, done, coll, menu;
   logic       a_start, a_active, go, vic, mo;
   logic [2:0] a_id;
   logic [3:0] hp;
   logic       play1, done1, coll1, menu1;
   logic       a_start1, a_active1, go1, vic1, mo1;
   logic [2:0] a_id1;
   logic [3:0] hp1;

   int errors = 0;
   int checks = 0;

   attack_scheduler #(
      .NUM_ATTACKS(2), .GAP_FRAMES(2), .ATTACK_TIMEOUT_FRAMES(4),
      .START_HP(5), .HIT_COOLDOWN_FRAMES(3)
   ) dut (
      .pclk(pclk), .rst(rst), .play_selected(play), .vblnk_in(vblnk),
      .attack_done(done), .collision(coll), .btn_menu(menu),
      .attack_start(a_start), .attack_id(a_id), .attack_active(a_active),
      .hp(hp), .game_over(go), .victory(vic), .menu_on(mo)
   );

   attack_scheduler #(
      .NUM_ATTACKS(2), .GAP_FRAMES(2), .ATTACK_TIMEOUT_FRAMES(4),
      .START_HP(1), .HIT_COOLDOWN_FRAMES(3)
   ) dut1 (
      .pclk(pclk), .rst(rst), .play_selected(play1), .vblnk_in(vblnk),
      .attack_done(done1), .collision(coll1), .btn_menu(menu1),
      .attack_start(a_start1), .attack_id(a_id1), .attack_active(a_active1),
      .hp(hp1), .game_over(go1), .victory(vic1), .menu_on(mo1)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic cyc();
      @(posedge pclk);
      #1;
   endtask

   // One-cycle vblnk pulse; the tick is processed at this edge. Follow with cyc().
   task automatic tick();
      vblnk = 1'b1;
      cyc();
      vblnk = 1'b0;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; vblnk = 1'b0;
      play = 1'b0; done = 1'b0; coll = 1'b0; menu = 1'b0;
      play1 = 1'b0; done1 = 1'b0; coll1 = 1'b0; menu1 = 1'b0;
      cyc(); cyc();
      check("rst_start",  8'(a_start),  8'd0);
      check("rst_id",     8'(a_id),     8'd0);
      check("rst_active", 8'(a_active), 8'd0);
      check("rst_hp",     8'(hp),       8'd5);
      check("rst_go",     8'(go),       8'd0);
      check("rst_vic",    8'(vic),      8'd0);
      check("rst_menu",   8'(mo),       8'd0);
      rst = 1'b0;
      cyc();

      // ---- Round 1: two attacks ended by attack_done, no collisions ----
      play = 1'b1; cyc();
      check("r1_gap_nostart", 8'(a_start), 8'd0);
      tick(); cyc();
      tick();
      check("r1_start0",   8'(a_start),  8'd1);
      check("r1_active0",  8'(a_active), 8'd1);
      check("r1_id0",      8'(a_id),     8'd0);
      cyc();
      check("r1_start_1cyc", 8'(a_start),  8'd0);
      check("r1_run_active", 8'(a_active), 8'd1);
      cyc(); cyc(); cyc();
      done = 1'b1; cyc(); done = 1'b0;
      check("r1_done_inactive", 8'(a_active), 8'd0);
      check("r1_id_adv",        8'(a_id),     8'd1);
      check("r1_no_vic_early",  8'(vic),      8'd0);
      tick(); cyc();
      tick();
      check("r1_start1", 8'(a_start), 8'd1);
      check("r1_id1",    8'(a_id),    8'd1);
      cyc(); cyc(); cyc(); cyc();
      done = 1'b1; cyc(); done = 1'b0;
      check("r1_victory",     8'(vic),      8'd1);
      check("r1_vic_hp",      8'(hp),       8'd5);
      check("r1_vic_inactive", 8'(a_active), 8'd0);
      check("r1_vic_no_go",   8'(go),       8'd0);
      cyc();
      check("r1_victory_1cyc", 8'(vic), 8'd0);
      play = 1'b0; cyc();
      check("r1_idle_hp", 8'(hp), 8'd5);

      // ---- Round 2: collision held in RUN, cooldown 3, timeout 4, reset mid-RUN ----
      play = 1'b1; cyc();
      tick(); cyc();
      tick();
      check("r2_start0", 8'(a_start), 8'd1);
      cyc();
      coll = 1'b1; cyc();
      check("r2_hit1", 8'(hp), 8'd4);
      tick(); cyc();
      check("r2_cool_hold", 8'(hp), 8'd4);
      tick(); cyc();
      tick();
      check("r2_cool_3tick", 8'(hp),       8'd4);
      check("r2_pre_timeout", 8'(a_active), 8'd1);
      cyc();
      check("r2_hit2", 8'(hp), 8'd3);
      tick();
      check("r2_timeout_inactive", 8'(a_active), 8'd0);
      check("r2_timeout_id",       8'(a_id),     8'd1);
      check("r2_timeout_hp",       8'(hp),       8'd3);
      cyc();
      tick(); cyc();
      tick();
      check("r2_start1", 8'(a_start), 8'd1);
      check("r2_gap_hp", 8'(hp),      8'd3);
      cyc();
      check("r2_start_nohit", 8'(hp), 8'd3);
      cyc();
      check("r2_hit3",   8'(hp),       8'd2);
      check("r2_active", 8'(a_active), 8'd1);
      rst = 1'b1; play = 1'b0; coll = 1'b0; cyc();
      check("r2_rst_hp",     8'(hp),       8'd5);
      check("r2_rst_active", 8'(a_active), 8'd0);
      check("r2_rst_id",     8'(a_id),     8'd0);
      check("r2_rst_pulses", 8'({a_start, go, vic, mo}), 8'd0);
      rst = 1'b0; cyc();

      // ---- Round 3: collision with non-final attack_done, then menu ----
      play = 1'b1; cyc();
      tick(); cyc();
      tick(); cyc();
      coll = 1'b1; done = 1'b1; cyc();
      coll = 1'b0; done = 1'b0;
      check("r3_both_hp", 8'(hp),   8'd4);
      check("r3_both_id", 8'(a_id), 8'd1);
      tick(); cyc();
      tick(); cyc();
      check("r3_run_active", 8'(a_active), 8'd1);
      menu = 1'b1; cyc(); menu = 1'b0;
      check("r3_menu_on",   8'(mo),       8'd1);
      check("r3_menu_inact", 8'(a_active), 8'd0);
      check("r3_menu_nogv", 8'({go, vic}), 8'd0);
      cyc();
      check("r3_menu_1cyc", 8'(mo), 8'd0);
      tick(); cyc();
      tick();
      check("r3_wait_nostart", 8'(a_start), 8'd0);
      cyc();
      play = 1'b0; cyc();
      play = 1'b1; cyc();
      tick(); cyc();
      tick();
      check("r3_idle_restart", 8'(a_start), 8'd1);
      cyc();
      play = 1'b0; cyc();
      check("r3_drop_inactive", 8'(a_active), 8'd0);
      check("r3_drop_nopulse",  8'({a_start, go, vic, mo}), 8'd0);
      cyc();

      // ---- START_HP=1: fatal collision together with final attack_done ----
      check("f_idle_hp", 8'(hp1), 8'd1);
      play1 = 1'b1; cyc();
      tick(); cyc();
      tick();
      check("f_start0", 8'(a_start1), 8'd1);
      cyc();
      done1 = 1'b1; cyc(); done1 = 1'b0;
      check("f_id1", 8'(a_id1), 8'd1);
      tick(); cyc();
      tick();
      check("f_start1", 8'(a_start1), 8'd1);
      cyc();
      coll1 = 1'b1; done1 = 1'b1; cyc();
      coll1 = 1'b0; done1 = 1'b0;
      check("f_game_over", 8'(go1),       8'd1);
      check("f_no_victory", 8'(vic1),     8'd0);
      check("f_hp0",       8'(hp1),       8'd0);
      check("f_inactive",  8'(a_active1), 8'd0);
      cyc();
      check("f_go_1cyc", 8'(go1), 8'd0);
      cyc();
      check("f_no_victory_later", 8'(vic1), 8'd0);
      check("f_hp_hold",          8'(hp1),  8'd0);
      play1 = 1'b0; cyc();
      check("f_idle_hp_reload", 8'(hp1), 8'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
